// File: rtl/up_timer_if.sv
// Control and display bundle for the two-digit BCD up-timer.
// The master side supplies limit/control, the slave side returns count and status.
interface up_timer_if;
   logic [7:0] data;
   logic       loadn;
   logic       start;
   logic       stop;
   logic       enable;
   logic [3:0] tens;
   logic [3:0] ones;
   logic       running;
   logic       tc;
   logic       done;

   modport master (
      output data, loadn, start, stop, enable,
      input  tens, ones, running, tc, done
   );

   modport slave (
      input  data, loadn, start, stop, enable,
      output tens, ones, running, tc, done
   );
endinterface

// File: rtl/up_timer.sv
// Two-digit BCD up-counter with a loadable limit and an IDLE/RUN/PAUSE/DONE sequencer.
// The count stops at the limit, pulses tc once, and can be restarted from DONE.
module up_timer (
   input logic        clock,
   input logic        clr,
   up_timer_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t     state_reg, state_next;
   logic [3:0] tens_reg, tens_next;
   logic [3:0] ones_reg, ones_next;
   logic [7:0] limit_reg, limit_next;
   logic       tc_reg, tc_next;

   logic [7:0] data_sat;
   logic [3:0] inc_tens;
   logic [3:0] inc_ones;
   logic       limit_zero;
   logic       inc_hits_limit;

   // Each limit digit is clamped to 9 so the stored limit is always valid BCD.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sat
         assign data_sat[gi*4 +: 4] = (bus.data[gi*4 +: 4] > 4'd9) ? 4'd9 : bus.data[gi*4 +: 4];
      end
   endgenerate

   // BCD increment that refuses to wrap past 99.
   always_comb begin
      inc_tens = tens_reg;
      inc_ones = ones_reg;
      if (ones_reg >= 4'd9) begin
         if (tens_reg < 4'd9) begin
            inc_ones = 4'd0;
            inc_tens = tens_reg + 4'd1;
         end
      end else begin
         inc_ones = ones_reg + 4'd1;
      end
   end

   assign limit_zero     = (limit_reg == 8'h00);
   assign inc_hits_limit = ({inc_tens, inc_ones} == limit_reg);

   always_comb begin
      state_next = state_reg;
      tens_next  = tens_reg;
      ones_next  = ones_reg;
      limit_next = limit_reg;
      tc_next    = 1'b0;

      if (!bus.loadn) begin
         limit_next = data_sat;
         tens_next  = 4'd0;
         ones_next  = 4'd0;
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  if (limit_zero) begin
                     state_next = DONE;
                     tc_next    = 1'b1;
                  end else begin
                     state_next = RUN;
                  end
               end
            end
            RUN: begin
               if (bus.stop) begin
                  state_next = PAUSE;
               end else if (bus.enable) begin
                  tens_next = inc_tens;
                  ones_next = inc_ones;
                  if (inc_hits_limit) begin
                     state_next = DONE;
                     tc_next    = 1'b1;
                  end
               end
            end
            PAUSE: begin
               if (bus.start && !bus.stop) begin
                  state_next = RUN;
               end
            end
            DONE: begin
               // A zero limit is already reached at 00, so a restart completes at once.
               if (bus.start) begin
                  tens_next = 4'd0;
                  ones_next = 4'd0;
                  if (limit_zero) begin
                     tc_next = 1'b1;
                  end else begin
                     state_next = RUN;
                  end
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge clr) begin
      if (clr) begin
         state_reg <= IDLE;
         tens_reg  <= 4'd0;
         ones_reg  <= 4'd0;
         limit_reg <= 8'h99;
         tc_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         tens_reg  <= tens_next;
         ones_reg  <= ones_next;
         limit_reg <= limit_next;
         tc_reg    <= tc_next;
      end
   end

   assign bus.tens    = tens_reg;
   assign bus.ones    = ones_reg;
   assign bus.tc      = tc_reg;
   assign bus.running = (state_reg == RUN);
   assign bus.done    = (state_reg == DONE);

endmodule
